mcr_fetch_ctl: RTL and testbench
================================

# mcr_fetch_ctl

Microcode RAM controller that sits directly behind the IRAM's external-memory port when the on-chip microcode RAM is not used. It turns 49-bit microinstruction fetch and write requests at a 14-bit PC address into sequences of 16-bit external memory beats over a req/ack handshake. It returns assembled instruction words to the IRAM. A one-entry prefetch buffer lets a prefetched word satisfy the following fetch without an external access.

## Interface
Parameters: none.

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- mcr_addr  in  14  microcode word address (PC)
- mcr_data_out  in  49  write data from IWR
- mcr_write  in  1  level write request; held until mcr_ready
- fetch  in  1  level fetch request; held until mcr_ready
- prefetch  in  1  single-cycle prefetch hint
- mcr_data_in  out  49  fetched microinstruction, registered
- mcr_ready  out  1  request complete; high until request drops
- busy  out  1  state is not IDLE
- mem_req  out  1  external beat request
- mem_we  out  1  beat is a write
- mem_addr  out  16  {mcr_addr, beat[1:0]}
- mem_wdata  out  16  write beat data
- mem_rdata  in  16  read beat data
- mem_ack  in  1  beat accepted/data valid

## Operation
- States: IDLE, RD, WR, DONE. A 2-bit beat counter runs 0..3.
- Buffer registers: pf_valid, pf_addr[13:0], pf_data[48:0], and a pf_fill flag marking a prefetch-initiated read.
- Requests are sampled only in IDLE. Priority: mcr_write > fetch > prefetch. mcr_addr is latched on acceptance.
- Write: go to WR and issue 4 write beats. Beat i carries mcr_data_out[16i+15:16i]; beat 3 carries {15'b0, mcr_data_out[48]}. After the beat-3 ack, go to DONE. If the address equals pf_addr with pf_valid set, pf_data is updated with the write data.
- Fetch hit (pf_valid and mcr_addr==pf_addr): no external access. Load mcr_data_in<=pf_data and go to DONE.
- Fetch miss: go to RD and issue 4 read beats. Beat i writes mem_rdata into bits [16i+15:16i]; beat 3 writes only bit 48 from mem_rdata[0]. After the beat-3 ack, go to DONE. The word is also loaded into the buffer: pf_addr and pf_data are updated and pf_valid is set.
- Prefetch: if it would hit, or the controller is not in IDLE, it is ignored (no-op). Otherwise go to RD with pf_fill=1. After the beat-3 ack, fill the buffer and return to IDLE with no mcr_ready and mcr_data_in unchanged.
- DONE: mcr_ready=1. Stay in DONE while the accepted request (fetch or mcr_write) remains high. Go to IDLE in the cycle after it drops (four-phase handshake).
- Memory handshake: mem_req, mem_addr, mem_we and mem_wdata are held stable until mem_ack is sampled high. The beat counter increments on ack. mem_req stays high into the next beat with new address and data, and drops the cycle after the beat-3 ack.
- busy = (state != IDLE).

## Timing
- Reset (async assert, sync release): state IDLE, beat 0, and all of the following cleared to 0: mcr_data_in, mcr_ready, mem_req, mem_we, mem_addr, mem_wdata, pf_valid, pf_addr, pf_data, pf_fill.
- Reset during RD/WR drops mem_req immediately. The external memory must tolerate an abandoned beat. The buffer is invalid after reset.
- Fetch hit: request in IDLE at cycle N gives mcr_ready=1 and valid data at N+1.
- Fetch miss with zero-wait ack (mem_ack high whenever mem_req is high): mem_req rises at N+1, beats complete at N+1..N+4, and mcr_ready=1 at N+5. Each wait cycle on mem_ack adds one cycle.
- A prefetch with zero-wait ack occupies N+1..N+4 and gives IDLE at N+5.
- A fetch raised during a prefetch read waits in IDLE sampling. If it targets the prefetched address, it hits at IDLE+1.
- mcr_ready deasserts in the cycle after the request drops. No new request is accepted in that same cycle.
- A simultaneous fetch and prefetch in IDLE serve the fetch; the prefetch is dropped.

## Test plan
- Reset mid-read: assert reset_n=0 during beat 2 -> mem_req=0 at once, state IDLE, pf_valid=0. A following fetch of the same address performs a full 4-beat read.
- Write then fetch: write 49'h1_2345_6789_ABCD to 14'h0100 -> beats carry addresses 16'h0400..0403 with data ABCD, 6789, 2345, 0001. Fetching 14'h0100 (the buffer is not holding that address) returns 49'h1_2345_6789_ABCD after 4 read beats.
- Zero-wait miss: fetch 14'h3FFF at cycle N -> mem_addr runs FFFC..FFFF and mcr_ready=1 at N+5. Inject 2 wait cycles on beat 1 -> mcr_ready at N+7.
- Prefetch hit: prefetch 14'h0010 and let it complete, then fetch 14'h0010 -> no mem_req, mcr_ready at the next cycle, data equals the memory contents. Prefetching 14'h0010 again -> no mem_req.
- Write-through coherence: buffer holds 14'h0020; write 49'h0 to 14'h0020; fetch 14'h0020 -> hit, data 49'h0.
- Priority and handshake: fetch and prefetch asserted together in IDLE -> only the fetch read occurs. Holding fetch 3 cycles after mcr_ready -> ready stays high, then IDLE one cycle after the drop.

Source files
------------

// File: rtl/mcr_fetch_ctl.sv
// External-memory microcode controller: splits 49-bit microinstruction reads and writes into four
// 16-bit beats, and keeps a one-entry prefetch buffer that can serve the next fetch without a beat.
module mcr_fetch_ctl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [13:0] mcr_addr,
  input  logic [48:0] mcr_data_out,
  input  logic        mcr_write,
  input  logic        fetch,
  input  logic        prefetch,
  output logic [48:0] mcr_data_in,
  output logic        mcr_ready,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state;
  logic [1:0]  beat;
  logic [13:0] lat_addr;
  logic [48:0] wr_data;
  logic [47:0] rd_buf;
  logic        req_wr;
  logic        pf_valid;
  logic        pf_fill;
  logic [13:0] pf_addr;
  logic [48:0] pf_data;

  logic        pf_hit;
  logic [1:0]  beat_nxt;
  logic [48:0] rd_word;
  logic        req_held;

  assign pf_hit   = pf_valid && (mcr_addr == pf_addr);
  assign beat_nxt = beat + 2'd1;
  assign rd_word  = {mem_rdata[0], rd_buf};
  assign req_held = req_wr ? mcr_write : fetch;
  assign busy     = (state != IDLE);

  // Beat 3 only carries the top bit of the 49-bit word.
  function automatic logic [15:0] wr_seg(input logic [48:0] d, input logic [1:0] b);
    case (b)
      2'd0:    wr_seg = d[15:0];
      2'd1:    wr_seg = d[31:16];
      2'd2:    wr_seg = d[47:32];
      default: wr_seg = {15'b0, d[48]};
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      beat        <= 2'd0;
      lat_addr    <= '0;
      wr_data     <= '0;
      rd_buf      <= '0;
      req_wr      <= 1'b0;
      pf_valid    <= 1'b0;
      pf_fill     <= 1'b0;
      pf_addr     <= '0;
      pf_data     <= '0;
      mcr_data_in <= '0;
      mcr_ready   <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          beat <= 2'd0;
          if (mcr_write) begin
            state     <= WR;
            req_wr    <= 1'b1;
            lat_addr  <= mcr_addr;
            wr_data   <= mcr_data_out;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {mcr_addr, 2'd0};
            mem_wdata <= wr_seg(mcr_data_out, 2'd0);
            if (pf_hit) pf_data <= mcr_data_out;
          end else if (fetch) begin
            req_wr <= 1'b0;
            if (pf_hit) begin
              state       <= DONE;
              mcr_data_in <= pf_data;
              mcr_ready   <= 1'b1;
            end else begin
              state    <= RD;
              pf_fill  <= 1'b0;
              lat_addr <= mcr_addr;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= {mcr_addr, 2'd0};
            end
          end else if (prefetch && !pf_hit) begin
            state    <= RD;
            pf_fill  <= 1'b1;
            lat_addr <= mcr_addr;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {mcr_addr, 2'd0};
          end
        end
        RD: if (mem_ack) begin
          case (beat)
            2'd0:    rd_buf[15:0]  <= mem_rdata;
            2'd1:    rd_buf[31:16] <= mem_rdata;
            2'd2:    rd_buf[47:32] <= mem_rdata;
            default: ;
          endcase
          if (beat == 2'd3) begin
            mem_req  <= 1'b0;
            pf_valid <= 1'b1;
            pf_addr  <= lat_addr;
            pf_data  <= rd_word;
            if (pf_fill) begin
              state   <= IDLE;
              pf_fill <= 1'b0;
            end else begin
              state       <= DONE;
              mcr_data_in <= rd_word;
              mcr_ready   <= 1'b1;
            end
          end else begin
            beat     <= beat_nxt;
            mem_addr <= {lat_addr, beat_nxt};
          end
        end
        WR: if (mem_ack) begin
          if (beat == 2'd3) begin
            state     <= DONE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mcr_ready <= 1'b1;
          end else begin
            beat      <= beat_nxt;
            mem_addr  <= {lat_addr, beat_nxt};
            mem_wdata <= wr_seg(wr_data, beat_nxt);
          end
        end
        default: begin
          // Four-phase: hold ready until the accepted request is released.
          if (!req_held) begin
            state     <= IDLE;
            mcr_ready <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcr_fetch_ctl.sv
// Bench for mcr_fetch_ctl: word-level reference model feeds beat and response scoreboards,
// checked by a memory responder and a ready monitor.
module tb_mcr_fetch_ctl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [13:0] mcr_addr = '0;
  logic [48:0] mcr_data_out = '0;
  logic        mcr_write = 1'b0;
  logic        fetch = 1'b0;
  logic        prefetch = 1'b0;
  logic [48:0] mcr_data_in;
  logic        mcr_ready, busy, mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  mcr_fetch_ctl dut (
    .clk(clk), .reset_n(reset_n), .mcr_addr(mcr_addr), .mcr_data_out(mcr_data_out),
    .mcr_write(mcr_write), .fetch(fetch), .prefetch(prefetch), .mcr_data_in(mcr_data_in),
    .mcr_ready(mcr_ready), .busy(busy), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [15:0] addr; logic [15:0] data; } beat_t;
  typedef struct { logic is_wr; logic [48:0] data; } resp_t;

  beat_t       exp_beats[$];
  resp_t       exp_resp[$];
  int          wait_q[$];
  logic [15:0] mem16[logic [15:0]];
  logic [48:0] ref_words[logic [13:0]];
  logic        m_pf_valid = 1'b0;
  logic [13:0] m_pf_addr = '0;
  bit          rand_waits = 1'b0;
  int          checks = 0, failures = 0, cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] f(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // Word contents for an address as the microcode program sees it.
  function automatic logic [48:0] ref_read(input logic [13:0] a);
    logic [15:0] b3;
    if (ref_words.exists(a)) return ref_words[a];
    b3 = f({a, 2'd3});
    return {b3[0], f({a, 2'd2}), f({a, 2'd1}), f({a, 2'd0})};
  endfunction

  always @(posedge clk) cyc++;

  // Memory responder: each acknowledged beat must match the next expected beat.
  int wcnt = 0;
  bit new_beat = 1'b1;
  always @(negedge clk) begin
    if (reset_n && mem_req) begin
      if (new_beat) begin
        if (wait_q.size() > 0) wcnt = wait_q.pop_front();
        else wcnt = rand_waits ? int'($urandom_range(0, 2)) : 0;
        new_beat = 1'b0;
      end
      if (wcnt == 0) begin
        if (exp_beats.size() == 0) begin
          chk("unexpected_beat", {47'b0, mem_we, mem_addr}, 64'hDEAD);
        end else begin
          beat_t e;
          e = exp_beats.pop_front();
          chk("beat_we", {63'b0, mem_we}, {63'b0, e.we});
          chk("beat_addr", {48'b0, mem_addr}, {48'b0, e.addr});
          if (e.we) chk("beat_wdata", {48'b0, mem_wdata}, {48'b0, e.data});
        end
        if (mem_we) mem16[mem_addr] = mem_wdata;
        mem_rdata = mem16.exists(mem_addr) ? mem16[mem_addr] : f(mem_addr);
        mem_ack = 1'b1;
        new_beat = 1'b1;
      end else begin
        wcnt--;
        mem_ack = 1'b0;
      end
    end else begin
      mem_ack = 1'b0;
      new_beat = 1'b1;
    end
  end

  // Response monitor: every rising mcr_ready consumes one expected response.
  logic prev_ready = 1'b0;
  always @(negedge clk) begin
    if (mcr_ready && !prev_ready) begin
      if (exp_resp.size() == 0) begin
        chk("unexpected_ready", 64'd1, 64'd0);
      end else begin
        resp_t r;
        r = exp_resp.pop_front();
        if (!r.is_wr) chk("fetch_data", {15'b0, mcr_data_in}, {15'b0, r.data});
      end
    end
    prev_ready = mcr_ready;
  end

  task automatic model_access(input bit is_wr, input bit is_pf, input logic [13:0] a,
                              input logic [48:0] d);
    bit hit;
    hit = m_pf_valid && (m_pf_addr == a);
    if (is_wr) begin
      for (int i = 0; i < 4; i++)
        exp_beats.push_back('{1'b1, {a, 2'(i)}, (i < 3) ? d[16*i +: 16] : {15'b0, d[48]}});
      ref_words[a] = d;
      exp_resp.push_back('{1'b1, 49'h0});
    end else begin
      if (!hit) begin
        for (int i = 0; i < 4; i++) exp_beats.push_back('{1'b0, {a, 2'(i)}, 16'h0});
        m_pf_valid = 1'b1;
        m_pf_addr  = a;
      end
      if (!is_pf) exp_resp.push_back('{1'b0, ref_read(a)});
    end
  endtask

  // kind: 0 write, 1 fetch, 2 prefetch, 3 fetch with simultaneous prefetch. Called at a negedge.
  task automatic do_op(input int kind, input logic [13:0] a, input logic [48:0] d,
                       input int hold, output int lat);
    int t0, n;
    model_access(kind == 0, kind == 2, a, d);
    t0 = cyc;
    mcr_addr = a;
    mcr_data_out = d;
    case (kind)
      0: mcr_write = 1'b1;
      1: fetch = 1'b1;
      2: prefetch = 1'b1;
      default: begin fetch = 1'b1; prefetch = 1'b1; end
    endcase
    @(negedge clk);
    prefetch = 1'b0;
    n = 0;
    if (kind == 2) begin
      while (busy && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) chk("prefetch_timeout", 64'd1, 64'd0);
      lat = cyc - t0;
    end else begin
      while (!mcr_ready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) chk("ready_timeout", 64'd1, 64'd0);
      lat = cyc - t0;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("ready_hold", {63'b0, mcr_ready}, 64'd1);
      end
      mcr_write = 1'b0;
      fetch = 1'b0;
      @(negedge clk);
      chk("ready_drop", {63'b0, mcr_ready}, 64'd0);
      chk("idle_after_drop", {63'b0, busy}, 64'd0);
    end
  endtask

  initial begin
    int lat, n;
    repeat (3) @(negedge clk);
    chk("rst_ready", {63'b0, mcr_ready}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_mem_req", {63'b0, mem_req}, 64'd0);
    chk("rst_mem_we", {63'b0, mem_we}, 64'd0);
    chk("rst_mem_addr", {48'b0, mem_addr}, 64'd0);
    chk("rst_data_in", {15'b0, mcr_data_in}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Write beats then a miss fetch of the same word.
    do_op(0, 14'h0100, 49'h1_2345_6789_ABCD, 0, lat);
    chk("write_latency", 64'(lat), 64'd5);
    do_op(1, 14'h0100, 49'h0, 0, lat);
    chk("wr_fetch_latency", 64'(lat), 64'd5);
    chk("wr_fetch_data", {15'b0, mcr_data_in}, {15'b0, 49'h1_2345_6789_ABCD});

    // Zero-wait miss at top of address space, then two waits on beat 1.
    do_op(1, 14'h3FFF, 49'h0, 0, lat);
    chk("miss_latency", 64'(lat), 64'd5);
    wait_q.push_back(0); wait_q.push_back(2); wait_q.push_back(0); wait_q.push_back(0);
    do_op(1, 14'h3FFE, 49'h0, 0, lat);
    chk("miss_wait_latency", 64'(lat), 64'd7);

    // Prefetch fill, hit, and repeated prefetch as a no-op.
    do_op(2, 14'h0010, 49'h0, 0, lat);
    chk("prefetch_latency", 64'(lat), 64'd5);
    do_op(1, 14'h0010, 49'h0, 0, lat);
    chk("hit_latency", 64'(lat), 64'd1);
    chk("hit_data", {15'b0, mcr_data_in}, {15'b0, ref_read(14'h0010)});
    do_op(2, 14'h0010, 49'h0, 0, lat);
    chk("prefetch_hit_noop", 64'(lat), 64'd1);

    // Write-through keeps the buffered word coherent.
    do_op(2, 14'h0020, 49'h0, 0, lat);
    do_op(0, 14'h0020, 49'h0, 0, lat);
    do_op(1, 14'h0020, 49'h0, 0, lat);
    chk("coherent_hit_latency", 64'(lat), 64'd1);
    chk("coherent_data", {15'b0, mcr_data_in}, 64'd0);

    // Simultaneous fetch and prefetch, fetch held 3 cycles after ready.
    do_op(3, 14'h0400, 49'h0, 3, lat);
    chk("priority_latency", 64'(lat), 64'd5);
    chk("priority_no_extra_beats", 64'(exp_beats.size()), 64'd0);

    // Reset in the middle of a read abandons it and empties the buffer.
    do_op(1, 14'h0200, 49'h0, 0, lat);
    for (int i = 0; i < 4; i++) exp_beats.push_back('{1'b0, {14'h0300, 2'(i)}, 16'h0});
    mcr_addr = 14'h0300;
    fetch = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!(mem_req && mem_addr[1:0] == 2'd2) && n < 50);
    if (n >= 50) chk("reset_test_timeout", 64'd1, 64'd0);
    reset_n = 1'b0;
    #1;
    chk("reset_mem_req", {63'b0, mem_req}, 64'd0);
    chk("reset_busy", {63'b0, busy}, 64'd0);
    fetch = 1'b0;
    exp_beats.delete();
    m_pf_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_op(1, 14'h0200, 49'h0, 0, lat);
    chk("post_reset_refetch_latency", 64'(lat), 64'd5);
    do_op(1, 14'h0300, 49'h0, 0, lat);
    chk("post_reset_abandoned_latency", 64'(lat), 64'd5);

    // Randomized traffic over a small address window to exercise hits and write-through.
    rand_waits = 1'b1;
    for (int k = 0; k < 60; k++) begin
      int kind;
      logic [48:0] d;
      kind = $urandom_range(0, 3);
      d = {$urandom, $urandom};
      do_op(kind, 14'h0008 + 14'($urandom_range(0, 5)), d, $urandom_range(0, 2), lat);
      chk("rand_beats_drained", 64'(exp_beats.size()), 64'd0);
    end

    repeat (3) @(negedge clk);
    chk("final_beats_empty", 64'(exp_beats.size()), 64'd0);
    chk("final_resp_empty", 64'(exp_resp.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
